tour_req_driver: RTL and testbench
==================================

// Module: tour_req_driver
// PURPOSE
//  On-chip initiator for the train-tour core's request interface. Buffers a host-loaded list of
//  (source,destination) station pairs, drives them on in_valid/source/destination one pair per cycle,
//  then waits for the core's single-cycle out_valid/cost and compares cost against an expected value.
//  Sits between the host/BIST controller and the train-tour core; replaces the software pattern driver on silicon.
// PARAMETERS
//  DEPTH    16     pair-buffer entries (power of 2, >=2)
//  TIMEOUT  30000  max cycles waited for core out_valid after the last pair
//  LAT_W    15     latency counter width (must hold TIMEOUT)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  ld_valid      in   1      host writes one pair into the buffer (accepted only in IDLE)
//  ld_src        in   4      station index of the pair source
//  ld_dst        in   4      station index of the pair destination
//  ld_clear      in   1      empties the buffer (IDLE only)
//  start         in   1      one-cycle pulse: run the buffered list
//  gap           in   4      idle cycles before in_valid rises (0 treated as 1)
//  exp_cost      in   4      expected cost, latched at start
//  in_valid      out  1      to core: pair valid
//  source        out  4      to core: source station
//  destination   out  4      to core: destination station
//  out_valid     in   1      from core: result valid
//  cost          in   4      from core: result cost
//  busy          out  1      high from accepted start until done
//  done          out  1      one-cycle pulse at end of a run
//  status        out  3      0 PASS,1 MISMATCH,2 TIMEOUT,3 MULTI_VALID,4 EMPTY,5 EARLY_VALID; held until next start
//  got_cost      out  4      captured cost; held until next start
//  latency       out  LAT_W  cycles from first idle cycle after last pair to out_valid
//  ld_ovf        out  1      sticky: write attempted while full; cleared by ld_clear
// BEHAVIOUR
//  Reset: all outputs 0; count=0; state IDLE. Reset mid-run aborts immediately, buffer contents discarded.
//  All outputs registered. source/destination are 0 whenever in_valid=0 (never X).
//  IDLE: ld_valid & count<DEPTH -> write entry[count], count++. ld_valid at full -> dropped, ld_ovf=1.
//    ld_clear -> count=0, ld_ovf=0; ld_clear and ld_valid same cycle: clear wins, write dropped.
//    start & count==0 -> next cycle done=1, status=EMPTY, no traffic. start & count>0 -> latch exp_cost,
//    gap; busy=1; -> GAP. ld_*/start ignored outside IDLE.
//  GAP: in_valid=0 for max(gap,1) cycles -> SEND.
//  SEND: in_valid=1 for exactly count consecutive cycles, entries 0..count-1 in load order, no bubbles.
//    -> WAIT on the cycle after the last pair.
//  WAIT: latency counts from 0 each cycle out_valid=0. out_valid=1 -> capture cost into got_cost,
//    latency frozen -> CHECK. latency reaching TIMEOUT -> status=TIMEOUT -> DONE.
//  CHECK (1 cycle): out_valid still 1 -> MULTI_VALID; else cost!=exp_cost -> MISMATCH; else PASS. -> DONE.
//  out_valid=1 during GAP or SEND -> status=EARLY_VALID, in_valid dropped next cycle -> DONE (abort).
//  DONE: done=1 one cycle, busy=0 -> IDLE. Buffer kept; a new start replays the same list.
//  Priority when simultaneous: reset > EARLY_VALID > TIMEOUT > MULTI_VALID > MISMATCH.
//  Counters saturate, never wrap; count uses log2(DEPTH)+1 bits.
// STRUCTURE
//  tour_pkg: STN_W=4, status codes (ST_PASS..ST_EARLY_VALID), state enum
//    {IDLE,GAP,SEND,WAIT,CHECK,DONE}.
//  One sub-module: tour_pair_buf (DEPTH x 8b register file, write port + sequential read pointer,
//    count/full flags). FSM, counters, compare in tour_req_driver.
// TESTING
//  Load 3 pairs (1,2)(2,5)(5,1), gap=2, exp=3, core returns cost 3 after 10 cycles -> in_valid high 3 cycles
//    in order, done, status=PASS, latency=10.
//  Same list, core returns 4 -> status=MISMATCH, got_cost=4; restart without reload replays identical traffic.
//  Core never asserts out_valid -> done exactly TIMEOUT cycles after WAIT entry, status=TIMEOUT.
//  Core holds out_valid 2 cycles -> status=MULTI_VALID.
//  start with empty buffer -> done next cycle, status=EMPTY, in_valid never rises.
//  Load DEPTH+1 pairs -> ld_ovf=1, DEPTH pairs sent; rst_n low mid-SEND -> in_valid=0 async, count=0.

Source files
------------

// File: rtl/tour_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tour_pkg                                                          |
// | Shared widths, result status codes, driver state encoding and the          |
// | (source,destination) pair record used by the train-tour request driver.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package tour_pkg;

  localparam int STN_W    = 4;   // station index width
  localparam int STATUS_W = 3;   // run result code width

  // Run result codes reported on status
  localparam logic [STATUS_W-1:0] ST_PASS        = 3'd0;
  localparam logic [STATUS_W-1:0] ST_MISMATCH    = 3'd1;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT     = 3'd2;
  localparam logic [STATUS_W-1:0] ST_MULTI_VALID = 3'd3;
  localparam logic [STATUS_W-1:0] ST_EMPTY       = 3'd4;
  localparam logic [STATUS_W-1:0] ST_EARLY_VALID = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [STN_W-1:0] src;
    logic [STN_W-1:0] dst;
  } pair_t;

endpackage
`default_nettype wire

// File: rtl/tour_pair_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tour_pair_buf                                                     |
// | DEPTH-entry (source,destination) list. Entries are appended in load order  |
// | and replayed from entry 0 through a sequential read pointer.               |
// |   wr_en/wr_src/wr_dst : append one pair (dropped and ovf set when full)    |
// |   clr                 : empty the list and clear ovf (wins over wr_en)     |
// |   rd_rst/rd_adv       : rewind / step the read pointer                     |
// |   rd_src/rd_dst       : pair at the read pointer                           |
// |   rd_done             : read pointer has passed the last stored entry      |
// |   count/ovf           : number of stored pairs / sticky overflow flag      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tour_pair_buf
  import tour_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [STN_W-1:0] wr_src,
  input  logic [STN_W-1:0] wr_dst,
  input  logic             clr,
  input  logic             rd_rst,
  input  logic             rd_adv,
  output logic [STN_W-1:0] rd_src,
  output logic [STN_W-1:0] rd_dst,
  output logic             rd_done,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_one   = CW'(1);

  pair_t         mem_q [DEPTH];
  pair_t         mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic          full;

  assign full = (count_q == c_depth);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    ptr_d   = ptr_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (wr_en) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_d[count_q[AW-1:0]] = '{src: wr_src, dst: wr_dst};
        count_d                = count_q + c_one;
      end
    end
    // Pointer saturates at DEPTH so rd_done stays true after a full-list replay.
    if (rd_rst) begin
      ptr_d = '0;
    end else if (rd_adv && (ptr_q != c_depth)) begin
      ptr_d = ptr_q + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Index wraps to 0 once the pointer saturates; the data is unused then.
  assign rd_src  = mem_q[ptr_q[AW-1:0]].src;
  assign rd_dst  = mem_q[ptr_q[AW-1:0]].dst;
  assign rd_done = (ptr_q >= count_q);
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: rtl/tour_req_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tour_req_driver                                                   |
// | On-chip initiator for the train-tour core. Replays a host-loaded pair list |
// | on in_valid/source/destination, waits for the core's out_valid/cost and    |
// | grades the captured cost against exp_cost.                                 |
// |   host side : ld_valid/ld_src/ld_dst/ld_clear, start, gap, exp_cost        |
// |   core side : in_valid/source/destination out, out_valid/cost in           |
// |   results   : busy, done, status, got_cost, latency, ld_ovf                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tour_req_driver
  import tour_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30000,
  parameter int LAT_W   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_valid,
  input  logic [STN_W-1:0]    ld_src,
  input  logic [STN_W-1:0]    ld_dst,
  input  logic                ld_clear,
  input  logic                start,
  input  logic [3:0]          gap,
  input  logic [STN_W-1:0]    exp_cost,
  output logic                in_valid,
  output logic [STN_W-1:0]    source,
  output logic [STN_W-1:0]    destination,
  input  logic                out_valid,
  input  logic [STN_W-1:0]    cost,
  output logic                busy,
  output logic                done,
  output logic [STATUS_W-1:0] status,
  output logic [STN_W-1:0]    got_cost,
  output logic [LAT_W-1:0]    latency,
  output logic                ld_ovf
);

  localparam int               CW        = $clog2(DEPTH) + 1;
  localparam logic [LAT_W-1:0] c_timeout = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] c_lat_one = LAT_W'(1);

  state_t                state_q, state_d;
  logic                  in_valid_q, in_valid_d;
  logic [STN_W-1:0]      source_q, source_d;
  logic [STN_W-1:0]      destination_q, destination_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [STN_W-1:0]      got_cost_q, got_cost_d;
  logic [LAT_W-1:0]      latency_q, latency_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [STN_W-1:0]      exp_q, exp_d;

  logic                  buf_wr, buf_clr, rd_rst, rd_adv, rd_done;
  logic [STN_W-1:0]      rd_src, rd_dst;
  logic [CW-1:0]         buf_count;
  logic [LAT_W-1:0]      lat_inc;

  tour_pair_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_src  (ld_src),
    .wr_dst  (ld_dst),
    .clr     (buf_clr),
    .rd_rst  (rd_rst),
    .rd_adv  (rd_adv),
    .rd_src  (rd_src),
    .rd_dst  (rd_dst),
    .rd_done (rd_done),
    .count   (buf_count),
    .ovf     (ld_ovf)
  );

  // Saturating wait counter
  assign lat_inc = (latency_q == '1) ? latency_q : (latency_q + c_lat_one);

  always_comb begin
    state_d       = state_q;
    in_valid_d    = 1'b0;
    source_d      = '0;
    destination_d = '0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    status_d      = status_q;
    got_cost_d    = got_cost_q;
    latency_d     = latency_q;
    gap_cnt_d     = gap_cnt_q;
    exp_d         = exp_q;
    buf_wr        = 1'b0;
    buf_clr       = 1'b0;
    rd_rst        = 1'b0;
    rd_adv        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // List edits are held off on a start cycle so the replayed list is
        // exactly what was stored before start.
        buf_clr = ld_clear & ~start;
        buf_wr  = ld_valid & ~ld_clear & ~start;
        if (start) begin
          got_cost_d = '0;
          latency_d  = '0;
          if (buf_count == '0) begin
            status_d = ST_EMPTY;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            status_d  = ST_PASS;
            exp_d     = exp_cost;
            gap_cnt_d = (gap == 4'd0) ? 4'd1 : gap;
            busy_d    = 1'b1;
            rd_rst    = 1'b1;
            state_d   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (out_valid) begin
          status_d = ST_EARLY_VALID;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else if (gap_cnt_q <= 4'd1) begin
          // Last idle cycle: register entry 0 so in_valid rises next cycle.
          in_valid_d    = 1'b1;
          source_d      = rd_src;
          destination_d = rd_dst;
          rd_adv        = 1'b1;
          state_d       = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      S_SEND: begin
        if (out_valid) begin
          status_d = ST_EARLY_VALID;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else if (rd_done) begin
          // The pair on the bus this cycle is the last one.
          state_d = S_WAIT;
        end else begin
          in_valid_d    = 1'b1;
          source_d      = rd_src;
          destination_d = rd_dst;
          rd_adv        = 1'b1;
        end
      end

      S_WAIT: begin
        if (out_valid) begin
          got_cost_d = cost;
          state_d    = S_CHECK;
        end else begin
          latency_d = lat_inc;
          if (lat_inc >= c_timeout) begin
            status_d = ST_TIMEOUT;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DONE;
          end
        end
      end

      S_CHECK: begin
        // A result still valid one cycle after capture outranks a bad cost.
        if (out_valid) begin
          status_d = ST_MULTI_VALID;
        end else if (got_cost_q != exp_q) begin
          status_d = ST_MISMATCH;
        end else begin
          status_d = ST_PASS;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_valid_q    <= 1'b0;
      source_q      <= '0;
      destination_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= '0;
      got_cost_q    <= '0;
      latency_q     <= '0;
      gap_cnt_q     <= '0;
      exp_q         <= '0;
    end else begin
      state_q       <= state_d;
      in_valid_q    <= in_valid_d;
      source_q      <= source_d;
      destination_q <= destination_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      status_q      <= status_d;
      got_cost_q    <= got_cost_d;
      latency_q     <= latency_d;
      gap_cnt_q     <= gap_cnt_d;
      exp_q         <= exp_d;
    end
  end

  assign in_valid    = in_valid_q;
  assign source      = source_q;
  assign destination = destination_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign got_cost    = got_cost_q;
  assign latency     = latency_q;

endmodule
`default_nettype wire

// File: tb/tb_tour_req_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tour_req_driver                                                |
// | Randomised scoreboard bench for tour_req_driver with a behavioural core.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_tour_req_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam int LAT_W   = 15;

  localparam logic [2:0] E_PASS  = 3'd0;
  localparam logic [2:0] E_MIS   = 3'd1;
  localparam logic [2:0] E_TO    = 3'd2;
  localparam logic [2:0] E_MULTI = 3'd3;
  localparam logic [2:0] E_EMPTY = 3'd4;
  localparam logic [2:0] E_EARLY = 3'd5;

  // core behaviour selector for run()
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_EARLY  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_valid = 1'b0;
  logic [3:0]       ld_src = '0;
  logic [3:0]       ld_dst = '0;
  logic             ld_clear = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       gap = '0;
  logic [3:0]       exp_cost = '0;
  logic             in_valid;
  logic [3:0]       source;
  logic [3:0]       destination;
  logic             out_valid = 1'b0;
  logic [3:0]       cost = '0;
  logic             busy;
  logic             done;
  logic [2:0]       status;
  logic [3:0]       got_cost;
  logic [LAT_W-1:0] latency;
  logic             ld_ovf;

  always #5 clk = ~clk;

  tour_req_driver #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .LAT_W   (LAT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_src      (ld_src),
    .ld_dst      (ld_dst),
    .ld_clear    (ld_clear),
    .start       (start),
    .gap         (gap),
    .exp_cost    (exp_cost),
    .in_valid    (in_valid),
    .source      (source),
    .destination (destination),
    .out_valid   (out_valid),
    .cost        (cost),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .got_cost    (got_cost),
    .latency     (latency),
    .ld_ovf      (ld_ovf)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  src;
    logic [3:0]  dst;
  } pair_exp_t;

  typedef struct {
    int unsigned      cyc;
    logic [2:0]       st;
    logic [3:0]       got;
    logic [LAT_W-1:0] lat;
  } res_exp_t;

  pair_exp_t pair_q[$];
  res_exp_t  res_q[$];
  pair_exp_t pe;
  res_exp_t  re;
  int        res_seen   = 0;
  int        res_pushed = 0;
  logic      mon_en     = 1'b0;

  // Reference list model: what the host has loaded, plus the overflow flag.
  logic [3:0] list_src[$];
  logic [3:0] list_dst[$];
  logic       model_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pair or a result.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (in_valid) begin
        n_tests++;
        if (pair_q.size() == 0) begin
          n_fail++;
          $display("FAIL pair_unexpected: in_valid=1 src=%0d dst=%0d at cycle %0d, expected no pair",
                   source, destination, cyc);
        end else begin
          pe = pair_q.pop_front();
          if (cyc !== pe.cyc || source !== pe.src || destination !== pe.dst) begin
            n_fail++;
            $display("FAIL pair: got cyc=%0d src=%0d dst=%0d expected cyc=%0d src=%0d dst=%0d",
                     cyc, source, destination, pe.cyc, pe.src, pe.dst);
          end
        end
      end else begin
        n_tests++;
        if (source !== 4'd0 || destination !== 4'd0) begin
          n_fail++;
          $display("FAIL idle_bus: got src=%0d dst=%0d expected 0/0 at cycle %0d", source, destination, cyc);
        end
      end
      if (done) begin
        n_tests++;
        if (res_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: done=1 at cycle %0d, expected none", cyc);
        end else begin
          re = res_q.pop_front();
          if (cyc !== re.cyc || status !== re.st || got_cost !== re.got ||
              latency !== re.lat || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL result: got cyc=%0d st=%0d cost=%0d lat=%0d busy=%0d expected cyc=%0d st=%0d cost=%0d lat=%0d busy=0",
                     cyc, status, got_cost, latency, busy, re.cyc, re.st, re.got, re.lat);
          end
        end
        res_seen++;
      end
    end
  end

  task automatic load(input logic [3:0] s, input logic [3:0] d);
    ld_valid = 1'b1; ld_src = s; ld_dst = d;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_src = '0; ld_dst = '0;
    if (list_src.size() < DEPTH) begin
      list_src.push_back(s);
      list_dst.push_back(d);
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic clear_list();
    ld_clear = 1'b1;
    @(posedge clk); #1;
    ld_clear = 1'b0;
    list_src.delete();
    list_dst.delete();
    model_ovf = 1'b0;
  endtask

  // One run: predict traffic/result from the list and the core behaviour,
  // play the core, then wait (bounded) for the result to be checked.
  task automatic run(input int g, input int mode, input int d, input int h,
                     input logic [3:0] c, input logic [3:0] e);
    int          n;
    int          geff;
    int unsigned k;
    res_exp_t    r;
    n    = list_src.size();
    geff = (g == 0) ? 1 : g;
    gap = 4'(g); exp_cost = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    if (n == 0) begin
      r = '{cyc: k, st: E_EMPTY, got: 4'd0, lat: '0};
    end else begin
      if (mode != M_EARLY)
        for (int i = 0; i < n; i++)
          pair_q.push_back('{cyc: k + geff + i, src: list_src[i], dst: list_dst[i]});
      if (mode == M_NORMAL)
        r = '{cyc: k + geff + n + d + 2,
              st: (h >= 2) ? E_MULTI : ((c != e) ? E_MIS : E_PASS),
              got: c, lat: LAT_W'(d)};
      else if (mode == M_NEVER)
        r = '{cyc: k + geff + n + TIMEOUT, st: E_TO, got: 4'd0, lat: LAT_W'(TIMEOUT)};
      else
        r = '{cyc: k + 1, st: E_EARLY, got: 4'd0, lat: '0};
    end
    res_q.push_back(r);
    res_pushed++;
    if (n > 0 && mode == M_EARLY) begin
      out_valid = 1'b1; cost = c;
      @(posedge clk); #1;
      out_valid = 1'b0; cost = '0;
    end else if (n > 0 && mode == M_NORMAL) begin
      repeat (geff + n + d) @(posedge clk);
      #1;
      out_valid = 1'b1; cost = c;
      repeat (h) @(posedge clk);
      #1;
      out_valid = 1'b0; cost = '0;
    end
    for (int i = 0; i < TIMEOUT + 100 && res_seen < res_pushed; i++) @(posedge clk);
    #1;
    if (res_seen < res_pushed) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_wait: got no done by cycle %0d expected done at cycle %0d", cyc, r.cyc);
      res_q.delete();
      pair_q.delete();
      res_seen = res_pushed;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int          g, mode, d, h, nl;
    logic [3:0]  c, e;
    int unsigned k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_valid", in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_got_cost", got_cost, 0);
    chk("rst_latency", latency, 0);
    chk("rst_ld_ovf", ld_ovf, 0);
    chk("rst_bus", {source, destination}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    load(4'd1, 4'd2); load(4'd2, 4'd5); load(4'd5, 4'd1);
    run(2, M_NORMAL, 10, 1, 4'd3, 4'd3);   // PASS, latency 10
    run(2, M_NORMAL, 10, 1, 4'd4, 4'd3);   // MISMATCH, replay same list
    run(2, M_NEVER, 0, 0, 4'd0, 4'd3);     // TIMEOUT
    run(1, M_NORMAL, 3, 2, 4'd3, 4'd3);    // MULTI_VALID
    run(0, M_NORMAL, 0, 1, 4'd7, 4'd7);    // gap 0 behaves as 1, latency 0
    run(3, M_EARLY, 0, 0, 4'd9, 4'd9);     // out_valid during GAP

    // Clear and write in the same cycle: clear wins
    load(4'd9, 4'd9);
    ld_clear = 1'b1; ld_valid = 1'b1; ld_src = 4'd6; ld_dst = 4'd6;
    @(posedge clk); #1;
    ld_clear = 1'b0; ld_valid = 1'b0; ld_src = '0; ld_dst = '0;
    list_src.delete(); list_dst.delete(); model_ovf = 1'b0;
    run(2, M_NORMAL, 1, 1, 4'd1, 4'd1);    // EMPTY, no traffic

    // Overflow: DEPTH+1 loads
    for (int i = 0; i < DEPTH + 1; i++) load(4'(i + 3), 4'(15 - i));
    chk("ld_ovf_set", ld_ovf, model_ovf);
    run(1, M_NORMAL, 5, 1, 4'd2, 4'd2);
    clear_list();
    chk("ld_ovf_clr", ld_ovf, model_ovf);

    // Randomised runs
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) clear_list();
      nl = $urandom_range(0, 3);
      for (int j = 0; j < nl; j++) load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      g = $urandom_range(0, 5);
      case ($urandom_range(0, 5))
        4:       mode = M_NEVER;
        5:       mode = M_EARLY;
        default: mode = M_NORMAL;
      endcase
      d = $urandom_range(0, 12);
      h = $urandom_range(1, 2);
      c = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 1) == 1) ? c : 4'($urandom_range(0, 15));
      run(g, mode, d, h, c, e);
      chk("rand_ld_ovf", ld_ovf, model_ovf);
    end

    // Reset asserted in the middle of SEND
    clear_list();
    for (int i = 0; i < DEPTH; i++) load(4'(i + 1), 4'(i + 8));
    gap = 4'd1; exp_cost = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    for (int i = 0; i < DEPTH; i++)
      pair_q.push_back('{cyc: k + 1 + i, src: list_src[i], dst: list_dst[i]});
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_valid", in_valid, 0);
    chk("arst_bus", {source, destination}, 0);
    chk("arst_busy", busy, 0);
    pair_q.delete();
    list_src.delete(); list_dst.delete(); model_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ld_ovf", ld_ovf, 0);
    run(2, M_NORMAL, 1, 1, 4'd0, 4'd0);    // count was cleared -> EMPTY

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
